// File: rtl/debounce_pkg.sv
// Shared types and helpers for the debounce block: FSM state encoding and
// wait-length arithmetic derived from clock frequency and hold time.
package debounce_pkg;

    typedef enum logic [1:0] {
        S0    = 2'd0,
        WAIT1 = 2'd1,
        S1    = 2'd2,
        WAIT0 = 2'd3
    } state_e;

    localparam int unsigned BOUNCE_CNT_W = 16;

    function automatic int unsigned wait_clocks_f(input int unsigned clk_hz,
                                                  input int unsigned time_us);
        return (clk_hz / 1_000_000) * time_us;
    endfunction

    // A one-clock wait still needs a 1-bit counter to exist.
    function automatic int unsigned cnt_width_f(input int unsigned clocks);
        return (clocks > 1) ? $clog2(clocks) : 1;
    endfunction

endpackage

// File: rtl/debounce_synchronizer.sv
// Multi-stage flop synchronizer for a single asynchronous input pin.
// q is the output of the last stage; all stages reset to 0.
module debounce_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    assign sync_d[0] = d;

    generate
        for (genvar gi = 1; gi < STAGES; gi++) begin : g_chain
            assign sync_d[gi] = sync_q[gi-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/debounce.sv
// Debouncer: synchronizer + 4-state stability FSM with registered level and edge pulses.
// Optional DEBOUNCE_BOUNCE_COUNT_EN adds a saturating count of abandoned attempts.
module debounce
    import debounce_pkg::*;
#(
    parameter int unsigned CLK_FREQUENCY = 100_000_000,
    parameter int unsigned WAIT_TIME_US  = 5000,
    parameter int          SYNC_STAGES   = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic debounce_out,
    output logic rise_pulse,
    output logic fall_pulse
`ifdef DEBOUNCE_BOUNCE_COUNT_EN
    ,
    output logic [BOUNCE_CNT_W-1:0] bounce_count
`endif
);

    localparam int unsigned WAIT_CLOCKS = wait_clocks_f(CLK_FREQUENCY, WAIT_TIME_US);
    localparam int unsigned CNT_W       = cnt_width_f(WAIT_CLOCKS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_CLOCKS - 1);

    logic             sync_in;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    debounce_synchronizer #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (async_in),
        .q  (sync_in)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S0: begin
                cnt_d = '0;
                if (sync_in) state_d = WAIT1;
            end
            WAIT1: begin
                if (!sync_in) begin
                    state_d = S0;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = S1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S1: begin
                cnt_d = '0;
                if (!sync_in) state_d = WAIT0;
            end
            WAIT0: begin
                if (sync_in) begin
                    state_d = S1;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = S0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S0;
                cnt_d   = '0;
            end
        endcase
    end

    // Level follows the committed state one cycle later; pulses mark its edges.
    always_comb begin
        out_d  = (state_q == S1) || (state_q == WAIT0);
        rise_d = out_d & ~out_q;
        fall_d = ~out_d & out_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S0;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign debounce_out = out_q;
    assign rise_pulse   = rise_q;
    assign fall_pulse   = fall_q;

`ifdef DEBOUNCE_BOUNCE_COUNT_EN
    logic                    abandon;
    logic [BOUNCE_CNT_W-1:0] bounce_q, bounce_d;

    always_comb begin
        abandon  = ((state_q == WAIT1) && !sync_in) ||
                   ((state_q == WAIT0) &&  sync_in);
        bounce_d = bounce_q;
        if (abandon && (bounce_q != {BOUNCE_CNT_W{1'b1}})) begin
            bounce_d = bounce_q + BOUNCE_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bounce_q <= '0;
        end else begin
            bounce_q <= bounce_d;
        end
    end

    assign bounce_count = bounce_q;
`else
    // Bounce statistics are not built; the core FSM is unchanged.
`endif

endmodule

// File: tb/tb_debounce.sv
// Self-checking bench for debounce: scoreboard of expected output events
// (cycle, level, pulse) plus table-driven and hand-written input sequences.
module tb_debounce;

    localparam int unsigned CLK_HZ    = 100_000_000;
    localparam int unsigned WAIT_US   = 1;
    localparam int          STAGES    = 2;
    localparam int          WAIT_CLKS = (CLK_HZ / 1_000_000) * WAIT_US;
    localparam int          LAT       = STAGES + WAIT_CLKS + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic async_in = 1'b0;
    logic debounce_out;
    logic rise_pulse;
    logic fall_pulse;
`ifdef DEBOUNCE_BOUNCE_COUNT_EN
    logic [15:0] bounce_count;
`endif

    debounce #(
        .CLK_FREQUENCY(CLK_HZ),
        .WAIT_TIME_US (WAIT_US),
        .SYNC_STAGES  (STAGES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .async_in    (async_in),
        .debounce_out(debounce_out),
        .rise_pulse  (rise_pulse),
        .fall_pulse  (fall_pulse)
`ifdef DEBOUNCE_BOUNCE_COUNT_EN
        ,
        .bounce_count(bounce_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   cyc;
        logic out;
        logic rise;
        logic fall;
    } exp_t;

    typedef struct {
        int high_len;
        bit exp_rise;
    } vec_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic prev_out = 1'b0;
    bit   mon_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_event(input int at, input logic o, input logic r, input logic f);
        exp_t x;
        x.cyc  = at;
        x.out  = o;
        x.rise = r;
        x.fall = f;
        exp_q.push_back(x);
    endtask

    // Any change of the level or any pulse is an event that must match the scoreboard head.
    always @(negedge clk) begin
        if (mon_en && (rise_pulse || fall_pulse || (debounce_out !== prev_out))) begin
            check("pulse_exclusive", 32'(rise_pulse & fall_pulse), 32'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event at cycle %0d: out=%0b rise=%0b fall=%0b, required no event",
                         cyc, debounce_out, rise_pulse, fall_pulse);
            end else begin
                e = exp_q.pop_front();
                $display("txn cycle %0d: out=%0b rise=%0b fall=%0b (expected cycle %0d)",
                         cyc, debounce_out, rise_pulse, fall_pulse, e.cyc);
                check("event_cycle", cyc, e.cyc);
                check("event_out", 32'(debounce_out), 32'(e.out));
                check("event_rise", 32'(rise_pulse), 32'(e.rise));
                check("event_fall", 32'(fall_pulse), 32'(e.fall));
            end
        end
        prev_out = debounce_out;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[6];
        int   n;
        int   last;
        logic v;

        vecs[0] = '{high_len: 1,   exp_rise: 1'b0};
        vecs[1] = '{high_len: 30,  exp_rise: 1'b0};
        vecs[2] = '{high_len: 99,  exp_rise: 1'b0};
        vecs[3] = '{high_len: 100, exp_rise: 1'b0};
        vecs[4] = '{high_len: 101, exp_rise: 1'b1};
        vecs[5] = '{high_len: 300, exp_rise: 1'b1};

        rst = 1'b1;
        async_in = 1'b0;
        tick(5);
        check("reset_out", 32'(debounce_out), 32'd0);
        check("reset_rise", 32'(rise_pulse), 32'd0);
        check("reset_fall", 32'(fall_pulse), 32'd0);
`ifdef DEBOUNCE_BOUNCE_COUNT_EN
        check("reset_bounce_count", 32'(bounce_count), 32'd0);
`endif
        rst = 1'b0;
        prev_out = 1'b0;
        mon_en = 1'b1;
        tick(10);

        // High pulses of varying length from stable low.
        for (int i = 0; i < 6; i++) begin
            async_in = 1'b1;
            n = cyc;
            if (vecs[i].exp_rise) push_event(n + 1 + LAT, 1'b1, 1'b1, 1'b0);
            tick(vecs[i].high_len);
            async_in = 1'b0;
            n = cyc;
            if (vecs[i].exp_rise) push_event(n + 1 + LAT, 1'b0, 1'b0, 1'b1);
            tick(300);
            $display("vector %0d: high_len=%0d exp_rise=%0b", i, vecs[i].high_len, vecs[i].exp_rise);
            check("vec_settled_low", 32'(debounce_out), 32'd0);
        end

        // Five toggles 20 cycles apart, ending high.
        v = 1'b0;
        last = 0;
        for (int k = 0; k < 5; k++) begin
            v = ~v;
            async_in = v;
            last = cyc;
            if (k < 4) tick(20);
        end
        push_event(last + 1 + LAT, 1'b1, 1'b1, 1'b0);
        tick(LAT - 1);
        check("toggle_before_rise", 32'(debounce_out), 32'd0);
        tick(150);
        check("toggle_after_rise", 32'(debounce_out), 32'd1);

        // From stable high: short low glitch ignored, then a held drop.
        async_in = 1'b0;
        tick(50);
        async_in = 1'b1;
        tick(200);
        check("low_glitch_held_high", 32'(debounce_out), 32'd1);
        async_in = 1'b0;
        n = cyc;
        push_event(n + 1 + LAT, 1'b0, 1'b0, 1'b1);
        tick(300);
        check("fall_settled", 32'(debounce_out), 32'd0);

        // Reset 50 cycles into a qualifying rise; rise restarts after reset.
        async_in = 1'b1;
        tick(50);
        rst = 1'b1;
        tick(3);
        check("midreset_out", 32'(debounce_out), 32'd0);
        check("midreset_rise", 32'(rise_pulse), 32'd0);
        check("midreset_fall", 32'(fall_pulse), 32'd0);
        rst = 1'b0;
        n = cyc;
        push_event(n + 1 + LAT, 1'b1, 1'b1, 1'b0);
        tick(LAT);
        check("post_reset_before_rise", 32'(debounce_out), 32'd0);
        tick(100);
        check("post_reset_after_rise", 32'(debounce_out), 32'd1);
        async_in = 1'b0;
        n = cyc;
        push_event(n + 1 + LAT, 1'b0, 1'b0, 1'b1);
        tick(300);

`ifdef DEBOUNCE_BOUNCE_COUNT_EN
        rst = 1'b1;
        tick(3);
        check("bc_after_reset", 32'(bounce_count), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            async_in = 1'b1;
            tick(30);
            async_in = 1'b0;
            tick(30);
        end
        tick(10);
        check("bc_three_aborts", 32'(bounce_count), 32'd3);
        check("bc_out_low", 32'(debounce_out), 32'd0);
`endif

        tick(20);
        check("pending_events", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
